// File: rtl/bmatch_sig_collector_if.sv
// Bus between the signature collector and its driver/CUT side.
// The onset bundle exists only when BMATCH_ONSET_CNT_EN is defined.
interface bmatch_sig_collector_if #(
  parameter int NI = 4,
  parameter int NO = 2
);
  localparam int TT = 1 << NI;

  logic                  start;
  logic                  stall;
  logic [NI-1:0]         pat;
  logic [NO-1:0]         resp;
  logic                  busy;
  logic                  done;
  logic [NO*TT-1:0]      sig;
`ifdef BMATCH_ONSET_CNT_EN
  logic [NO*(NI+1)-1:0]  onset;

  modport slave  (input  start, stall, resp, output pat, busy, done, sig, onset);
  modport master (output start, stall, resp, input  pat, busy, done, sig, onset);
`else
  modport slave  (input  start, stall, resp, output pat, busy, done, sig);
  modport master (output start, stall, resp, input  pat, busy, done, sig);
`endif
endinterface

// File: rtl/bmatch_sig_collector.sv
// Walks all 2**NI input minterms through a combinational CUT and packs each output's truth table.
// Optional per-output onset counters are built when BMATCH_ONSET_CNT_EN is defined.
module bmatch_sig_collector #(
  parameter int NI = 4,
  parameter int NO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bmatch_sig_collector_if.slave   bus
);
  localparam int TT = 1 << NI;
  localparam int OW = NI + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [NI-1:0]      r_pat;
  logic [NI-1:0]      w_patNext;
  logic [NO*TT-1:0]   r_sig;
  logic [NO*TT-1:0]   w_sigNext;
  logic [TT-1:0]      w_slice;
`ifdef BMATCH_ONSET_CNT_EN
  logic [NO*OW-1:0]   r_onset;
  logic [NO*OW-1:0]   w_onsetNext;
`endif

  // The CUT output is sampled in the same cycle its pattern is presented, so pat=k lands in bit k.
  always_comb begin
    w_stateNext = r_state;
    w_patNext   = r_pat;
    w_sigNext   = r_sig;
    w_slice     = '0;
`ifdef BMATCH_ONSET_CNT_EN
    w_onsetNext = r_onset;
`endif
    unique case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_stateNext = RUN;
          w_patNext   = '0;
          w_sigNext   = '0;
`ifdef BMATCH_ONSET_CNT_EN
          w_onsetNext = '0;
`endif
        end else if (r_state == DONE) begin
          w_stateNext = IDLE;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          for (int j = 0; j < NO; j++) begin
            w_slice        = r_sig[j*TT +: TT];
            w_slice[r_pat] = bus.resp[j];
            w_sigNext[j*TT +: TT] = w_slice;
`ifdef BMATCH_ONSET_CNT_EN
            w_onsetNext[j*OW +: OW] = r_onset[j*OW +: OW] + OW'(bus.resp[j]);
`endif
          end
          if (r_pat == NI'(TT-1)) begin
            w_stateNext = DONE;
            w_patNext   = '0;
          end else begin
            w_patNext   = r_pat + 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_sig   <= '0;
`ifdef BMATCH_ONSET_CNT_EN
      r_onset <= '0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_pat   <= w_patNext;
      r_sig   <= w_sigNext;
`ifdef BMATCH_ONSET_CNT_EN
      r_onset <= w_onsetNext;
`endif
    end
  end

  // busy and done fall straight out of the state register, so they are glitch-free.
  assign bus.pat  = r_pat;
  assign bus.sig  = r_sig;
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
`ifdef BMATCH_ONSET_CNT_EN
  assign bus.onset = r_onset;
`endif

endmodule
